// File: rtl/alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_unit
// Description : Execution-stage ALU with a start/done handshake.
//               add/sub/and/or/slt complete in a single cycle; sll/srl/sra
//               run on an iterative shifter that moves one bit per cycle, so
//               busy stays high for shamt cycles.
// Ports       : clk, rst (async, active-high)
//               start       - request, accepted only while busy==0
//               ALUControl  - op select (000 add, 001 sub, 010 and, 011 or,
//                             101 slt, 100 sll, 110 srl, 111 sra)
//               SrcA, SrcB  - operands; SrcB[SHW-1:0] is the shift amount
//               ALUResult   - registered result, held until next completion
//               Zero        - registered (ALUResult == 0)
//               busy        - high while a multi-cycle shift is in flight
//               done        - 1-cycle pulse when ALUResult/Zero update
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SLL = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_SRL = 3'b110;
  localparam logic [2:0] OP_SRA = 3'b111;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [2:0]       op, op_next;
  logic [SHW-1:0]   count, count_next;
  logic [WIDTH-1:0] result_next;
  logic             zero_next;
  logic             done_next;

  logic [WIDTH-1:0] alu_val;
  logic [WIDTH-1:0] shifted;
  logic [SHW-1:0]   shamt;
  logic             is_shift;

  assign shamt    = SrcB[SHW-1:0];
  assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                    (ALUControl == OP_SRA);
  assign busy     = (state == SHIFT);

  // Single-cycle operations; shift codes never select this value.
  always_comb begin
    alu_val = '0;
    case (ALUControl)
      OP_ADD:  alu_val = SrcA + SrcB;
      OP_SUB:  alu_val = SrcA - SrcB;
      OP_AND:  alu_val = SrcA & SrcB;
      OP_OR:   alu_val = SrcA | SrcB;
      OP_SLT:  alu_val = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
      default: alu_val = '0;
    endcase
  end

  // One-bit step of the iterative shifter, driven by the captured op.
  always_comb begin
    shifted = shreg;
    case (op)
      OP_SLL:  shifted = {shreg[WIDTH-2:0], 1'b0};
      OP_SRL:  shifted = {1'b0, shreg[WIDTH-1:1]};
      OP_SRA:  shifted = {shreg[WIDTH-1], shreg[WIDTH-1:1]};
      default: shifted = shreg;
    endcase
  end

  always_comb begin
    state_next  = state;
    shreg_next  = shreg;
    op_next     = op;
    count_next  = count;
    result_next = ALUResult;
    zero_next   = Zero;
    done_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (!is_shift) begin
            result_next = alu_val;
            zero_next   = (alu_val == '0);
            done_next   = 1'b1;
          end else if (shamt == '0) begin
            // Zero-distance shift is a pass-through and needs no SHIFT state.
            result_next = SrcA;
            zero_next   = (SrcA == '0);
            done_next   = 1'b1;
          end else begin
            shreg_next = SrcA;
            op_next    = ALUControl;
            count_next = shamt;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        shreg_next = shifted;
        count_next = count - SHW'(1);
        // Result is published only on the final step so partial values never
        // appear on ALUResult.
        if (count == SHW'(1)) begin
          result_next = shifted;
          zero_next   = (shifted == '0);
          done_next   = 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      op        <= '0;
      count     <= '0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      done      <= 1'b0;
    end else begin
      state     <= state_next;
      shreg     <= shreg_next;
      op        <= op_next;
      count     <= count_next;
      ALUResult <= result_next;
      Zero      <= zero_next;
      done      <= done_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_unit
// Description : Directed self-checking bench for alu_seq_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  alu_control = 3'b000;
  logic [31:0] src_a = '0;
  logic [31:0] src_b = '0;
  logic [31:0] alu_result;
  logic        zero;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;

  alu_seq_unit #(.WIDTH(32), .SHW(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ALUControl (alu_control),
    .SrcA       (src_a),
    .SrcB       (src_b),
    .ALUResult  (alu_result),
    .Zero       (zero),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a request at the falling edge, return 1ns after the accepting edge
  // with start already dropped.
  task automatic issue(input logic [2:0] ctl, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    alu_control = ctl;
    src_a = a;
    src_b = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  initial begin
    int n;
    int busy_cnt;
    int done_cnt;
    int done_at;
    logic [31:0] res_at_done;
    logic held_ok;

    // 1. asynchronous reset pulse in the middle of a cycle
    #2 rst = 1'b1;
    #2;
    check("rst_result", alu_result, 32'h0);
    check("rst_zero", {31'b0, zero}, 32'h1);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_done", {31'b0, done}, 32'h0);
    rst = 1'b0;

    // 2. add wrap into sign bit, then back-to-back sub
    issue(3'b000, 32'h7FFF_FFFF, 32'h1);
    check("add_result", alu_result, 32'h8000_0000);
    check("add_zero", {31'b0, zero}, 32'h0);
    check("add_done", {31'b0, done}, 32'h1);
    issue(3'b001, 32'd5, 32'd5);
    check("sub_result", alu_result, 32'h0);
    check("sub_zero", {31'b0, zero}, 32'h1);
    check("sub_done", {31'b0, done}, 32'h1);
    @(posedge clk); #1;
    check("idle_done_low", {31'b0, done}, 32'h0);
    check("idle_hold", alu_result, 32'h0);

    // 3. slt / and / or
    issue(3'b101, 32'hFFFF_FFFF, 32'h1);
    check("slt_result", alu_result, 32'h1);
    issue(3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    check("and_result", alu_result, 32'h00F0_00F0);
    issue(3'b011, 32'hF000_0000, 32'h0000_000F);
    check("or_result", alu_result, 32'hF000_000F);

    // 4a. sra by 31
    issue(3'b111, 32'h8000_0000, 32'd31);
    n = 0; busy_cnt = 0; held_ok = 1'b1;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      if (alu_result !== 32'hF000_000F) held_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check("sra_latency", n, 32'd31);
    check("sra_busy_cycles", busy_cnt, 32'd31);
    check("sra_no_partial", {31'b0, held_ok}, 32'h1);
    check("sra_result", alu_result, 32'hFFFF_FFFF);
    check("sra_busy_end", {31'b0, busy}, 32'h0);
    @(posedge clk); #1;
    check("sra_done_pulse", {31'b0, done}, 32'h0);

    // 4b. srl by 31
    issue(3'b110, 32'h8000_0000, 32'd31);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("srl_latency", n, 32'd31);
    check("srl_result", alu_result, 32'h0000_0001);

    // 4c. sll by 0 completes in one cycle without busy
    issue(3'b100, 32'h1, 32'h0);
    check("sll0_result", alu_result, 32'h1);
    check("sll0_done", {31'b0, done}, 32'h1);
    check("sll0_busy", {31'b0, busy}, 32'h0);

    // 5. sll 3 by 4 with an ignored add request during busy
    issue(3'b100, 32'h3, 32'd4);
    check("sll4_busy", {31'b0, busy}, 32'h1);
    done_cnt = 0; done_at = 0; res_at_done = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 2) begin
        start = 1'b1;
        alu_control = 3'b000;
        src_a = 32'h1;
        src_b = 32'h1;
      end else begin
        start = 1'b0;
        src_a = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      if (done) begin
        done_cnt++;
        done_at = c;
        res_at_done = alu_result;
      end
    end
    check("sll4_done_count", done_cnt, 32'd1);
    check("sll4_latency", done_at, 32'd4);
    check("sll4_result", res_at_done, 32'h30);
    check("sll4_final", alu_result, 32'h30);

    // 6. srl aborted by reset mid-shift
    issue(3'b110, 32'hFFFF_0000, 32'd10);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_result", alu_result, 32'h0);
    check("abort_zero", {31'b0, zero}, 32'h1);
    check("abort_busy", {31'b0, busy}, 32'h0);
    check("abort_done", {31'b0, done}, 32'h0);
    rst = 1'b0;
    done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    check("abort_no_done", done_cnt, 32'd0);
    check("abort_idle", busy_cnt, 32'd0);
    check("abort_hold", alu_result, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
